// File: rtl/axi_burst_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_burst_mem_slave
//
// AXI4 burst slave memory with transaction IDs and a user sideband. It has
// independent write and read engines that share one word-addressed memory.
// Only INCR bursts of full-width beats are supported. Word index for beat n
// is (addr >> log2(DATA_WIDTH/8)) + n. The index wraps modulo MEM_DEPTH.
//
// Optional feature macro: AXI_BURST_MEM_SLAVE_DECERR_EN
//   When it is defined, any beat whose unwrapped word index is >= MEM_DEPTH
//   is out of range:
//     - an out-of-range write beat is dropped, and the burst answers DECERR;
//     - an out-of-range read beat returns zero data with DECERR.
//   When it is undefined, indices simply wrap and DECERR is never returned.
//
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   awid/awaddr/awlen             write address channel (awvalid/awready)
//   wdata/wstrb/wlast/wuser       write data channel (wvalid/wready)
//   bid/bresp/buser               write response channel (bvalid/bready)
//   arid/araddr/arlen             read address channel (arvalid/arready)
//   rid/rdata/rresp/rlast/ruser   read data channel (rvalid/rready)
// ---------------------------------------------------------------------------
module axi_burst_mem_slave #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int MEM_DEPTH  = 64
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic                    awvalid,
    output logic                    awready,

    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic [USER_WIDTH-1:0]   wuser,
    input  logic                    wvalid,
    output logic                    wready,

    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic [USER_WIDTH-1:0]   buser,
    output logic                    bvalid,
    input  logic                    bready,

    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic                    arvalid,
    output logic                    arready,

    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic [USER_WIDTH-1:0]   ruser,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB  = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(STRB);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    // Unwrapped index: wide enough for the largest base word plus 255 beats,
    // so the out-of-range test never aliases.
    localparam int UW    = ADDR_WIDTH + 9;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [UW-1:0] aw_base, ar_base;
    logic [UW-1:0] w_idx, r_idx;
    logic [7:0]    w_len, w_beat, r_len, r_beat;
    logic          w_err, w_dec;
    logic          aw_fire, w_fire, ar_fire, r_fire;
    logic          w_last, r_at_last;
    logic          w_oor, r_oor_first, r_oor_next;

    assign aw_base   = UW'(awaddr >> OFFS);
    assign ar_base   = UW'(araddr >> OFFS);
    assign aw_fire   = awvalid && awready;
    assign w_fire    = wvalid && wready;
    assign ar_fire   = arvalid && arready;
    assign r_fire    = rvalid && rready;
    assign w_last    = (w_beat == w_len);
    assign r_at_last = (r_beat == r_len);

`ifdef AXI_BURST_MEM_SLAVE_DECERR_EN
    assign w_oor       = (w_idx   >= UW'(MEM_DEPTH));
    assign r_oor_first = (ar_base >= UW'(MEM_DEPTH));
    assign r_oor_next  = (r_idx   >= UW'(MEM_DEPTH));
`else
    assign w_oor       = 1'b0;
    assign r_oor_first = 1'b0;
    assign r_oor_next  = 1'b0;
`endif

    // ---------------------------------------------------------------- write
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // The burst length comes from awlen alone. wlast is only checked for
    // consistency, so a wrong wlast cannot shorten or extend a burst.
    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_last) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bid    <= '0;
            buser  <= '0;
            w_idx  <= '0;
            w_len  <= '0;
            w_beat <= '0;
            w_err  <= 1'b0;
            w_dec  <= 1'b0;
        end else if (aw_fire) begin
            bid    <= awid;
            w_idx  <= aw_base;
            w_len  <= awlen;
            w_beat <= '0;
            w_err  <= 1'b0;
            w_dec  <= 1'b0;
        end else if (w_fire) begin
            w_idx  <= w_idx + UW'(1);
            w_beat <= w_beat + 8'd1;
            buser  <= wuser;
            if (wlast != w_last) w_err <= 1'b1;
            if (w_oor)           w_dec <= 1'b1;
        end
    end

    // DECERR outranks SLVERR when both happened in one burst.
    assign bresp = w_dec ? 2'b11 : (w_err ? 2'b10 : 2'b00);

    // Memory contents deliberately survive reset.
    always_ff @(posedge aclk) begin
        if (w_fire && !w_oor) begin
            for (int b = 0; b < STRB; b++) begin
                if (wstrb[b]) mem[w_idx[IDX_W-1:0]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && r_at_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign rlast = (r_state == R_DATA) && r_at_last;
    assign ruser = '0;

    // rdata is a register loaded one beat ahead: on the AR handshake it gets
    // beat 0, and on each R handshake the following beat. r_idx always
    // points at the word after the one being presented. The memory read uses
    // the pre-edge contents, which gives read-before-write ordering.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rid    <= '0;
            rdata  <= '0;
            rresp  <= 2'b00;
            r_idx  <= '0;
            r_len  <= '0;
            r_beat <= '0;
        end else if (ar_fire) begin
            rid    <= arid;
            r_len  <= arlen;
            r_beat <= '0;
            r_idx  <= ar_base + UW'(1);
            rdata  <= r_oor_first ? '0 : mem[ar_base[IDX_W-1:0]];
            rresp  <= r_oor_first ? 2'b11 : 2'b00;
        end else if (r_fire && !r_at_last) begin
            r_beat <= r_beat + 8'd1;
            r_idx  <= r_idx + UW'(1);
            rdata  <= r_oor_next ? '0 : mem[r_idx[IDX_W-1:0]];
            rresp  <= r_oor_next ? 2'b11 : 2'b00;
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_mem_slave
//
// Self-checking bench for axi_burst_mem_slave with default parameters
// (ID 4, ADDR 8, DATA 32, USER 1, MEM_DEPTH 64). It keeps a plain word-array
// model of the memory. Write bursts update the model beat by beat, and
// expected read data, bresp and rresp come from the model. It honours
// AXI_BURST_MEM_SLAVE_DECERR_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_axi_burst_mem_slave;

    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 2000;

`ifdef AXI_BURST_MEM_SLAVE_DECERR_EN
    localparam logic [1:0] WRAP_BRESP = 2'b11;
    localparam bit         DEC_ON     = 1'b1;
`else
    localparam logic [1:0] WRAP_BRESP = 2'b00;
    localparam bit         DEC_ON     = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  awid;
    logic [7:0]  awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic [0:0]  wuser;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic [0:0]  buser;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [7:0]  araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [0:0]  ruser;
    logic        rvalid;
    logic        rready;

    axi_burst_mem_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] wr_data [256];
    logic [3:0]  wr_strb [256];
    logic [0:0]  wr_user [256];
    logic        wr_last [256];
    logic [31:0] rd_data [256];

    typedef struct {
        logic [3:0]  wid;
        logic [7:0]  addr;
        int          len;
        int          early;
        logic [31:0] base;
        logic [3:0]  rd_id;
        int          mode;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_first;
    } vec_t;

    vec_t vecs [4];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int word_index(input logic [7:0] addr, input int beat);
        return int'(addr[7:2]) + beat;
    endfunction

    function automatic bit out_of_range(input int idx);
        return DEC_ON && (idx >= DEPTH);
    endfunction

    // Applies one write burst to the model and returns the response it earns.
    function automatic logic [1:0] model_write(input logic [7:0] addr, input int len);
        bit err;
        bit dec;
        int idx;
        err = 1'b0;
        dec = 1'b0;
        for (int k = 0; k <= len; k++) begin
            idx = word_index(addr, k);
            if (wr_last[k] != (k == len)) err = 1'b1;
            if (out_of_range(idx)) dec = 1'b1;
            else begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[k][b]) model_mem[idx % DEPTH][8*b +: 8] = wr_data[k][8*b +: 8];
            end
        end
        if (dec) return 2'b11;
        if (err) return 2'b10;
        return 2'b00;
    endfunction

    // early < 0: wlast on the final beat only; otherwise wlast only on that beat.
    task automatic load_burst(input logic [31:0] base, input int len, input int early);
        for (int k = 0; k <= len; k++) begin
            wr_data[k] = base + 32'(k);
            wr_strb[k] = 4'hF;
            wr_user[k] = 1'(k);
            wr_last[k] = (early < 0) ? (k == len) : (k == early);
        end
    endtask

    task automatic load_random(input int len);
        for (int k = 0; k <= len; k++) begin
            wr_data[k] = $urandom;
            wr_strb[k] = 4'($urandom_range(0, 15));
            wr_user[k] = 1'($urandom_range(0, 1));
            wr_last[k] = (k == len) ^ ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic apply_stimulus_write(input logic [3:0] id, input logic [7:0] addr, input int len,
                                        input bit gaps, output logic [1:0] got_bresp);
        logic [1:0] exp_resp;
        int cyc;
        got_bresp = 2'bxx;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < TIMEOUT) begin @(negedge aclk); cyc++; end
        check_output("awready_wait", awready, 1);
        if (!awready) begin awvalid = 1'b0; return; end
        @(negedge aclk);
        awvalid = 1'b0;
        check_output("awready_busy", awready, 0);
        for (int k = 0; k <= len; k++) begin
            if (gaps) begin
                wvalid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge aclk);
            end
            wdata = wr_data[k]; wstrb = wr_strb[k]; wuser = wr_user[k]; wlast = wr_last[k];
            wvalid = 1'b1;
            cyc = 0;
            while (!wready && cyc < TIMEOUT) begin @(negedge aclk); cyc++; end
            if (!wready) begin
                check_output("wready_wait", wready, 1);
                wvalid = 1'b0;
                return;
            end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        exp_resp = model_write(addr, len);
        cyc = 0;
        while (!bvalid && cyc < TIMEOUT) begin @(negedge aclk); cyc++; end
        check_output("bvalid_wait", bvalid, 1);
        if (!bvalid) return;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) @(negedge aclk);
            check_output("bvalid_hold", bvalid, 1);
        end
        check_output("bid", bid, id);
        check_output("bresp", bresp, exp_resp);
        check_output("buser", buser, wr_user[len]);
        got_bresp = bresp;
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check_output("awready_after_b", awready, 1);
    endtask

    // mode 0: rready always 1, 1: rready 1010..., 2: random rready.
    task automatic apply_stimulus_read(input logic [3:0] id, input logic [7:0] addr, input int len,
                                       input int mode);
        int beat;
        int cyc;
        int idx;
        bit rr;
        bit stalled;
        logic [31:0] held_data;
        logic        held_last;
        logic [1:0]  held_resp;
        @(negedge aclk);
        arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < TIMEOUT) begin @(negedge aclk); cyc++; end
        check_output("arready_wait", arready, 1);
        if (!arready) begin arvalid = 1'b0; return; end
        @(negedge aclk);
        arvalid = 1'b0;
        check_output("first_rvalid", rvalid, 1);
        check_output("arready_busy", arready, 0);
        beat = 0; cyc = 0; stalled = 1'b0;
        held_data = '0; held_last = 1'b0; held_resp = 2'b00;
        while (beat <= len && cyc < TIMEOUT) begin
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            rready = rr;
            if (mode == 0) check_output("no_bubble", rvalid, 1);
            if (rvalid) begin
                if (stalled) begin
                    check_output("stall_rdata", rdata, held_data);
                    check_output("stall_rlast", rlast, held_last);
                    check_output("stall_rresp", rresp, held_resp);
                end
                if (rr) begin
                    idx = word_index(addr, beat);
                    check_output("rid", rid, id);
                    check_output("rdata", rdata, out_of_range(idx) ? 32'h0 : model_mem[idx % DEPTH]);
                    check_output("rresp", rresp, out_of_range(idx) ? 2'b11 : 2'b00);
                    check_output("rlast", rlast, (beat == len));
                    check_output("ruser", ruser, 0);
                    rd_data[beat] = rdata;
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_data = rdata; held_last = rlast; held_resp = rresp;
                end
            end
            @(negedge aclk);
            cyc++;
        end
        rready = 1'b0;
        check_output("read_beats", beat, len + 1);
        check_output("rvalid_after_last", rvalid, 0);
        check_output("arready_after_last", arready, 1);
    endtask

    initial begin
        logic [1:0]  got;
        logic [31:0] saved_w0;
        logic [31:0] plan2 [4];
        int          len_w;
        int          len_r;

        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wuser = '0; wvalid = 1'b0;
        bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        // Reset state.
        check_output("rst_awready", awready, 1);
        check_output("rst_arready", arready, 1);
        check_output("rst_wready", wready, 0);
        check_output("rst_bvalid", bvalid, 0);
        check_output("rst_rvalid", rvalid, 0);
        check_output("rst_bid", bid, 0);
        check_output("rst_bresp", bresp, 0);
        check_output("rst_buser", buser, 0);
        check_output("rst_rid", rid, 0);
        check_output("rst_rdata", rdata, 0);
        check_output("rst_rresp", rresp, 0);
        check_output("rst_rlast", rlast, 0);
        check_output("rst_ruser", ruser, 0);

        // Fill the whole memory so that every later read has a known value.
        for (int k = 0; k < DEPTH; k++) begin
            wr_data[k] = $urandom; wr_strb[k] = 4'hF; wr_user[k] = 1'($urandom_range(0, 1));
            wr_last[k] = (k == DEPTH - 1);
        end
        apply_stimulus_write(4'h0, 8'h00, DEPTH - 1, 1'b0, got);
        check_output("fill_bresp", got, 2'b00);
        saved_w0 = model_mem[0];

        // Table-driven write-then-read vectors.
        vecs[0] = '{wid: 4'h3, addr: 8'h10, len: 0, early: -1, base: 32'hDEADBEEF,
                    rd_id: 4'h5, mode: 0, exp_bresp: 2'b00, exp_first: 32'hDEADBEEF};
        vecs[1] = '{wid: 4'h7, addr: 8'h40, len: 3, early: 1, base: 32'h11110000,
                    rd_id: 4'h2, mode: 0, exp_bresp: 2'b10, exp_first: 32'h11110000};
        vecs[2] = '{wid: 4'h1, addr: 8'h80, len: 7, early: -1, base: 32'hA0000000,
                    rd_id: 4'h9, mode: 1, exp_bresp: 2'b00, exp_first: 32'hA0000000};
        vecs[3] = '{wid: 4'h4, addr: 8'hFC, len: 1, early: -1, base: 32'hC0DE0000,
                    rd_id: 4'h6, mode: 0, exp_bresp: WRAP_BRESP, exp_first: 32'hC0DE0000};
        for (int v = 0; v < 4; v++) begin
            load_burst(vecs[v].base, vecs[v].len, vecs[v].early);
            apply_stimulus_write(vecs[v].wid, vecs[v].addr, vecs[v].len, 1'b0, got);
            check_output($sformatf("tbl%0d_bresp", v), got, vecs[v].exp_bresp);
            apply_stimulus_read(vecs[v].rd_id, vecs[v].addr, vecs[v].len, vecs[v].mode);
            check_output($sformatf("tbl%0d_first", v), rd_data[0], vecs[v].exp_first);
        end

        // Wrapped second beat: lands in word 0 unless the range check drops it.
        apply_stimulus_read(4'h8, 8'h00, 0, 0);
        check_output("wrap_word0", rd_data[0], DEC_ON ? saved_w0 : 32'hC0DE0001);

        // Partial strobe over all-ones background, read with no stalls.
        load_burst(32'hFFFFFFFF, 3, -1);
        for (int k = 0; k < 4; k++) wr_data[k] = 32'hFFFFFFFF;
        apply_stimulus_write(4'h2, 8'h20, 3, 1'b0, got);
        load_burst(32'h00000001, 3, -1);
        wr_strb[1] = 4'h3;
        apply_stimulus_write(4'h2, 8'h20, 3, 1'b0, got);
        apply_stimulus_read(4'hB, 8'h20, 3, 0);
        plan2[0] = 32'h00000001; plan2[1] = 32'hFFFF0002;
        plan2[2] = 32'h00000003; plan2[3] = 32'h00000004;
        for (int k = 0; k < 4; k++) check_output($sformatf("strb_beat%0d", k), rd_data[k], plan2[k]);

        // Reset in the middle of a read burst.
        @(negedge aclk);
        check_output("mid_arready_pre", arready, 1);
        arid = 4'hA; araddr = 8'h80; arlen = 8'd7; arvalid = 1'b1; rready = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        repeat (2) @(negedge aclk);
        check_output("mid_rvalid_pre", rvalid, 1);
        rready = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        check_output("mid_rst_rvalid", rvalid, 0);
        check_output("mid_rst_rlast", rlast, 0);
        check_output("mid_rst_arready", arready, 1);
        @(negedge aclk);
        aresetn = 1'b1;
        apply_stimulus_read(4'hC, 8'h80, 7, 2);

        // Concurrent engines on disjoint halves of the memory.
        for (int it = 0; it < 12; it++) begin
            logic [7:0] wa;
            logic [7:0] ra;
            wa = 8'($urandom_range(0, 15) * 4);
            ra = 8'(128 + $urandom_range(0, 15) * 4);
            len_w = $urandom_range(0, 15);
            len_r = $urandom_range(0, 15);
            load_random(len_w);
            fork
                apply_stimulus_write(4'($urandom_range(0, 15)), wa, len_w, 1'b1, got);
                apply_stimulus_read(4'($urandom_range(0, 15)), ra, len_r, 2);
            join
        end

        // Long random bursts, including wrap and out-of-range beats.
        for (int it = 0; it < 4; it++) begin
            len_w = $urandom_range(0, 255);
            load_random(len_w);
            apply_stimulus_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), len_w, 1'b1, got);
            apply_stimulus_read(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                                $urandom_range(0, 255), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
